// File: rtl/shape_processor_ctrl_bank.sv
// Multi-channel CTRL register bank for the shape processor family.
// Each channel holds SHAPE/OPERATION, a sticky ILLEGAL flag and a saturating
// error counter. There is an optional shadow copy that a COMMIT write transfers
// to the active copy.
module shape_processor_ctrl_bank #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter bit          SHADOWED     = 1'b0,
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned AW           = $clog2(2 * NUM_CHANNELS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write,
    input  logic [AW-1:0]             write_addr,
    input  logic [31:0]               write_data,
    input  logic                      read,
    input  logic [AW-1:0]             read_addr,
    output logic [31:0]               read_data,
    output logic                      read_valid,
    output logic                      error,
    output logic [3*NUM_CHANNELS-1:0] shape_out,
    output logic [3*NUM_CHANNELS-1:0] operation_out
);

    localparam logic [2:0]           KeepVal = 3'd7;
    localparam logic [ERR_CNT_W-1:0] CntMax  = '1;

    logic [2:0]           act_shape_q [NUM_CHANNELS];
    logic [2:0]           act_shape_d [NUM_CHANNELS];
    logic [2:0]           act_op_q    [NUM_CHANNELS];
    logic [2:0]           act_op_d    [NUM_CHANNELS];
    logic [2:0]           shd_shape_q [NUM_CHANNELS];
    logic [2:0]           shd_shape_d [NUM_CHANNELS];
    logic [2:0]           shd_op_q    [NUM_CHANNELS];
    logic [2:0]           shd_op_d    [NUM_CHANNELS];
    logic [ERR_CNT_W-1:0] cnt_q       [NUM_CHANNELS];
    logic [ERR_CNT_W-1:0] cnt_d       [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] illegal_q, illegal_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        error_q, error_d;

    logic [2:0]  wr_shape, wr_op, tgt_shape, tgt_op, res_shape, res_op;
    logic        wr_reserved;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign unused_wdata = ^{write_data[31:7], write_data[3]};

    function automatic logic pair_legal(logic [2:0] s, logic [2:0] o);
        case (o)
            3'd0, 3'd1: return s <= 3'd2;
            3'd2:       return s == 3'd1;
            3'd3, 3'd4: return s == 3'd2;
            default:    return 1'b0;
        endcase
    endfunction

    // Read mux and all next-state logic; reads always see pre-write state.
    always_comb begin
        act_shape_d = act_shape_q;
        act_op_d    = act_op_q;
        shd_shape_d = shd_shape_q;
        shd_op_d    = shd_op_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        error_d     = 1'b0;
        wr_shape    = write_data[2:0];
        wr_op       = write_data[6:4];
        wr_reserved = (wr_shape inside {[3'd3:3'd6]}) || (wr_op inside {3'd5, 3'd6});
        tgt_shape   = '0;
        tgt_op      = '0;
        res_shape   = '0;
        res_op      = '0;
        rd_val      = '0;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (read_addr == AW'(2 * c)) begin
                rd_val = {25'd0, act_op_q[c], 1'b0, act_shape_q[c]};
            end else if (read_addr == AW'(2 * c + 1)) begin
                rd_val[0] = illegal_q[c];
                rd_val[1] = SHADOWED && ((shd_shape_q[c] != act_shape_q[c]) ||
                                         (shd_op_q[c] != act_op_q[c]));
                rd_val[8 +: ERR_CNT_W] = cnt_q[c];
            end
        end
        read_valid_d = read;
        read_data_d  = read ? rd_val : read_data_q;

        if (write) begin
            if (write_addr > AW'(2 * NUM_CHANNELS)) begin
                error_d = 1'b1;
            end else if (write_addr == AW'(2 * NUM_CHANNELS)) begin
                if (SHADOWED && write_data[0]) begin
                    act_shape_d = shd_shape_q;
                    act_op_d    = shd_op_q;
                end
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (write_addr == AW'(2 * c)) begin
                    // KEEP resolves against whichever copy the write lands in.
                    tgt_shape = SHADOWED ? shd_shape_q[c] : act_shape_q[c];
                    tgt_op    = SHADOWED ? shd_op_q[c] : act_op_q[c];
                    res_shape = (wr_shape == KeepVal) ? tgt_shape : wr_shape;
                    res_op    = (wr_op == KeepVal) ? tgt_op : wr_op;
                    if (!wr_reserved && pair_legal(res_shape, res_op)) begin
                        if (SHADOWED) begin
                            shd_shape_d[c] = res_shape;
                            shd_op_d[c]    = res_op;
                        end else begin
                            act_shape_d[c] = res_shape;
                            act_op_d[c]    = res_op;
                        end
                    end else begin
                        error_d      = 1'b1;
                        illegal_d[c] = 1'b1;
                        if (cnt_q[c] != CntMax) cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end else if (write_addr == AW'(2 * c + 1) && write_data[0]) begin
                    illegal_d[c] = 1'b0;
                    cnt_d[c]     = '0;
                end
            end
        end
    end

    // State registers; synchronous reset overrides any same-cycle access.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                act_shape_q[c] <= '0;
                act_op_q[c]    <= '0;
                shd_shape_q[c] <= '0;
                shd_op_q[c]    <= '0;
                cnt_q[c]       <= '0;
            end
            illegal_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            act_shape_q  <= act_shape_d;
            act_op_q     <= act_op_d;
            shd_shape_q  <= shd_shape_d;
            shd_op_q     <= shd_op_d;
            cnt_q        <= cnt_d;
            illegal_q    <= illegal_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            error_q      <= error_d;
        end
    end

    // Pack the active registers onto the per-channel datapath outputs.
    always_comb begin
        shape_out     = '0;
        operation_out = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            shape_out[3*c +: 3]     = act_shape_q[c];
            operation_out[3*c +: 3] = act_op_q[c];
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign error      = error_q;

endmodule

// File: tb/tb_shape_processor_ctrl_bank.sv
// Directed bench: one unshadowed and one shadowed 4-channel bank.
module tb_shape_processor_ctrl_bank;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        w0, r0, w1, r1;
    logic [3:0]  wa0, ra0, wa1, ra1;
    logic [31:0] wd0, wd1, rd0, rd1;
    logic        rv0, rv1, er0, er1;
    logic [11:0] sh0, op0, sh1, op1;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] got;

    shape_processor_ctrl_bank #(.NUM_CHANNELS(4), .SHADOWED(1'b0), .ERR_CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .write(w0), .write_addr(wa0), .write_data(wd0),
        .read(r0), .read_addr(ra0), .read_data(rd0), .read_valid(rv0), .error(er0),
        .shape_out(sh0), .operation_out(op0)
    );

    shape_processor_ctrl_bank #(.NUM_CHANNELS(4), .SHADOWED(1'b1), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .write(w1), .write_addr(wa1), .write_data(wd1),
        .read(r1), .read_addr(ra1), .read_data(rd1), .read_valid(rv1), .error(er1),
        .shape_out(sh1), .operation_out(op1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write pulse; returns at the negedge where the resulting error pulse is visible.
    task automatic wr(input bit sel, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin w1 = 1'b1; wa1 = a; wd1 = d; end
        else     begin w0 = 1'b1; wa0 = a; wd0 = d; end
        @(negedge clk);
        w0 = 1'b0;
        w1 = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel) begin r1 = 1'b1; ra1 = a; end
        else     begin r0 = 1'b1; ra0 = a; end
        @(negedge clk);
        r0 = 1'b0;
        r1 = 1'b0;
        check_eq("read_valid", {31'd0, sel ? rv1 : rv0}, 32'd1);
        d = sel ? rd1 : rd0;
    endtask

    initial begin
        rst = 1'b1;
        {w0, r0, w1, r1} = '0;
        {wa0, ra0, wa1, ra1} = '0;
        wd0 = '0;
        wd1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_error", {31'd0, er0}, 32'd0);
        check_eq("rst_rvalid", {31'd0, rv0}, 32'd0);
        check_eq("rst_rdata", rd0, 32'd0);
        check_eq("rst_shape0", {20'd0, sh0}, 32'd0);
        check_eq("rst_op0", {20'd0, op0}, 32'd0);
        check_eq("rst_shape1", {20'd0, sh1, op1}, 32'd0);

        // ch2 RECTANGLE/IS_SQUARE accepted
        wr(0, 4'd4, 32'h21);
        check_eq("ch2_err", {31'd0, er0}, 32'd0);
        check_eq("ch2_shape", {20'd0, sh0}, 32'h040);
        check_eq("ch2_op", {20'd0, op0}, 32'h080);

        // KEEP_SHAPE resolves to CIRCLE, IS_EQUILATERAL illegal
        wr(0, 4'd0, 32'h37);
        check_eq("keep_rej_err", {31'd0, er0}, 32'd1);
        check_eq("keep_rej_shape", {20'd0, sh0}, 32'h040);
        rd(0, 4'd1, got);
        check_eq("status0", got, 32'h101);
        wr(0, 4'd0, 32'h72);
        check_eq("keep_op_err", {31'd0, er0}, 32'd0);
        check_eq("keep_op_shape", {20'd0, sh0}, 32'h042);
        check_eq("keep_op_op", {20'd0, op0}, 32'h080);

        // KEEP/KEEP is an accepted no-op
        wr(0, 4'd4, 32'h77);
        check_eq("keepkeep_err", {31'd0, er0}, 32'd0);
        check_eq("keepkeep_shape", {20'd0, sh0, op0}, 32'h042080);

        // Same-cycle read and write of ch0 CTRL
        @(negedge clk);
        w0 = 1'b1; wa0 = 4'd0; wd0 = 32'h32;
        r0 = 1'b1; ra0 = 4'd0;
        @(negedge clk);
        w0 = 1'b0;
        r0 = 1'b0;
        check_eq("rw_old", rd0, 32'h02);
        check_eq("rw_err", {31'd0, er0}, 32'd0);
        rd(0, 4'd0, got);
        check_eq("rw_new", got, 32'h32);
        rd(0, 4'd0, got);
        @(negedge clk);
        check_eq("rdata_hold", rd0, 32'h32);
        check_eq("rvalid_low", {31'd0, rv0}, 32'd0);

        // 300 back-to-back reserved-shape writes to ch1
        @(negedge clk);
        w0 = 1'b1; wa0 = 4'd2; wd0 = 32'h05;
        repeat (300) @(negedge clk);
        w0 = 1'b0;
        check_eq("sat_err", {31'd0, er0}, 32'd1);
        check_eq("sat_shape", {20'd0, sh0}, 32'h042);
        rd(0, 4'd3, got);
        check_eq("sat_status", got, 32'hFF01);
        wr(0, 4'd3, 32'h0);
        check_eq("w0_err", {31'd0, er0}, 32'd0);
        rd(0, 4'd3, got);
        check_eq("w0_status", got, 32'hFF01);
        wr(0, 4'd3, 32'h1);
        rd(0, 4'd3, got);
        check_eq("w1c_status", got, 32'h0);

        // Unmapped write and reads; COMMIT ignored when unshadowed
        wr(0, 4'hF, 32'h21);
        check_eq("unmap_err", {31'd0, er0}, 32'd1);
        rd(0, 4'd1, got);
        check_eq("unmap_st0", got, 32'h101);
        rd(0, 4'd5, got);
        check_eq("unmap_st2", got, 32'h0);
        rd(0, 4'hF, got);
        check_eq("unmap_read", got, 32'h0);
        wr(0, 4'd8, 32'h1);
        check_eq("commit_ns_err", {31'd0, er0}, 32'd0);
        check_eq("commit_ns_shape", {20'd0, sh0}, 32'h042);
        rd(0, 4'd8, got);
        check_eq("commit_read", got, 32'h0);

        // Shadowed: write lands in shadow, COMMIT makes it active
        wr(1, 4'd6, 32'h42);
        check_eq("shd_err", {31'd0, er1}, 32'd0);
        check_eq("shd_op", {20'd0, op1}, 32'h0);
        rd(1, 4'd7, got);
        check_eq("shd_pending", got, 32'h2);
        rd(1, 4'd6, got);
        check_eq("shd_ctrl_act", got, 32'h0);
        wr(1, 4'd8, 32'h1);
        check_eq("commit_err", {31'd0, er1}, 32'd0);
        check_eq("commit_shape", {20'd0, sh1}, 32'h400);
        check_eq("commit_op", {20'd0, op1}, 32'h800);
        rd(1, 4'd7, got);
        check_eq("commit_pending", got, 32'h0);

        // Reset wins over a same-cycle accepted write
        @(negedge clk);
        rst = 1'b1;
        w0 = 1'b1; wa0 = 4'd4; wd0 = 32'h12;
        @(negedge clk);
        w0 = 1'b0;
        check_eq("rstw_err", {31'd0, er0}, 32'd0);
        check_eq("rstw_shape", {20'd0, sh0}, 32'h0);
        check_eq("rstw_op", {20'd0, op0}, 32'h0);
        check_eq("rstw_shd", {20'd0, sh1, op1}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_err_after", {31'd0, er0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
